lpddr2_port_arbiter: RTL and testbench

Two-port arbiter and transaction sequencer that shares the single LPDDR2 memory controller port between the CPU instruction-fetch path (read-only) and the data load/store path. It sits between the pipeline's memory stages and the LPDDR2 controller. It issues one transaction at a time, holds address and data stable for the whole transaction, and tracks completion through the controller's state output. It returns read data and a one-cycle acknowledge to the winning requester, and flags stalled transactions with a watchdog.

---
 rtl/lpddr2_port_arbiter.sv | 140 ++++++++++++++
 tb/tb_lpddr2_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lpddr2_port_arbiter.sv
// Shares the single LPDDR2 controller port between instruction fetch (read-only)
// and data load/store, one transaction at a time, with round-robin on ties.
module lpddr2_port_arbiter #(
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              iCLK,
  input  logic              iRST_n,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  output logic              mem_read_req,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [3:0]        mem_state,
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(TIMEOUT - 2);

  localparam logic [2:0] S_WAIT_INIT = 3'd0;
  localparam logic [2:0] S_ARB       = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_BUSY      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [3:0] MS_IDLE = 4'd1;

  logic [2:0]       state, state_nxt;
  logic             grant_d, grant_i;
  logic             last_i;    // 1: fetch was granted last
  logic             owner_i;   // 1: current transaction belongs to fetch
  logic             lat_we;
  logic [CNT_W-1:0] wd_cnt;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    grant_d   = 1'b0;
    grant_i   = 1'b0;
    case (state)
      S_WAIT_INIT: if (mem_state == MS_IDLE) state_nxt = S_ARB;
      S_ARB: begin
        if (d_req && i_req) begin
          grant_d = last_i;
          grant_i = !last_i;
        end else begin
          grant_d = d_req;
          grant_i = i_req;
        end
        if (grant_d || grant_i) state_nxt = S_ISSUE;
      end
      S_ISSUE:  if (mem_state != MS_IDLE) state_nxt = S_BUSY;
      S_BUSY:   if (mem_state == MS_IDLE) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_ARB;
      default:  state_nxt = S_WAIT_INIT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in the block.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state         <= S_WAIT_INIT;
      last_i        <= 1'b1;
      owner_i       <= 1'b0;
      lat_we        <= 1'b0;
      wd_cnt        <= '0;
      d_rdata       <= '0;
      i_rdata       <= '0;
      d_ack         <= 1'b0;
      i_ack         <= 1'b0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != S_ARB);
      d_ack <= 1'b0;
      i_ack <= 1'b0;

      // Watchdog runs for the whole time the controller owns the transaction.
      if ((state == S_ISSUE || state == S_BUSY) && wd_cnt != CNT_MAX) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == CNT_PRE) timeout_err <= 1'b1;
      end

      case (state)
        S_ARB: begin
          if (grant_d || grant_i) begin
            // mem_addr / mem_wdata double as the transaction latch.
            mem_addr      <= grant_d ? d_addr : i_addr;
            mem_wdata     <= grant_d ? d_wdata : '0;
            lat_we        <= grant_d & d_we;
            mem_write_req <= grant_d & d_we;
            mem_read_req  <= !(grant_d & d_we);
            owner_i       <= grant_i;
            last_i        <= grant_i;
            wd_cnt        <= '0;
          end
        end
        S_ISSUE: begin
          if (state_nxt == S_BUSY) begin
            mem_read_req  <= 1'b0;
            mem_write_req <= 1'b0;
          end
        end
        S_BUSY: begin
          if (state_nxt == S_DONE) begin
            d_ack <= !owner_i;
            i_ack <= owner_i;
            if (!lat_we) begin
              if (owner_i) i_rdata <= mem_rdata;
              else         d_rdata <= mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Scoreboard bench for lpddr2_port_arbiter: a controller model checks issued
// operations, a monitor checks every ack against the expected queue.
module tb_lpddr2_port_arbiter;
  localparam int ADDR_W  = 27;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic              iCLK = 1'b0;
  logic              iRST_n;
  logic              d_req, d_we, i_req;
  logic [ADDR_W-1:0] d_addr, i_addr, mem_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata, i_rdata, mem_wdata, mem_rdata;
  logic              d_ack, i_ack, mem_read_req, mem_write_req, busy, timeout_err;
  logic [3:0]        mem_state;

  lpddr2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .iCLK(iCLK), .iRST_n(iRST_n),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_state(mem_state), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { logic port; logic [31:0] d_rd; logic [31:0] i_rd; } ack_t;
  typedef struct { logic we; logic [26:0] addr; logic [31:0] wdata; } op_t;

  ack_t        ack_q[$];
  op_t         op_q[$];
  logic [31:0] mem_arr [int];
  logic [31:0] exp_d = '0, exp_i = '0;
  int          n_vec = 0, n_fail = 0;
  bit          ctrl_ready = 1'b0;
  int          busy_len = 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Controller model: accepts one cycle after a request, completes after busy_len.
  initial begin : model
    op_t         e;
    logic [26:0] a;
    logic [31:0] wd;
    logic        we_seen;
    bit          ok, aborted;
    int          cnt;
    mem_state = 4'd0;
    mem_rdata = '0;
    forever begin
      @(negedge iCLK);
      mem_state = ctrl_ready ? 4'd1 : 4'd0;
      if (iRST_n && ctrl_ready && (mem_read_req || mem_write_req)) begin
        we_seen = mem_write_req;
        a  = mem_addr;
        wd = mem_wdata;
        check("mem_req_exclusive", 64'(mem_read_req & mem_write_req), 64'd0);
        n_vec++;
        if (op_q.size() == 0) begin
          n_fail++;
          $display("FAIL mem_op_unexpected: got addr 0x%0h we %0d, none queued", a, we_seen);
        end else begin
          e = op_q.pop_front();
          check("mem_we", 64'(we_seen), 64'(e.we));
          check("mem_addr", 64'(a), 64'(e.addr));
          if (e.we) check("mem_wdata", 64'(wd), 64'(e.wdata));
        end
        mem_state = 4'd2;
        ok = 1'b1; aborted = 1'b0; cnt = 0;
        while (cnt < busy_len && !aborted) begin
          @(negedge iCLK);
          if (!iRST_n) aborted = 1'b1;
          else begin
            if (mem_addr !== a || mem_wdata !== wd) ok = 1'b0;
            cnt++;
          end
        end
        if (!aborted) begin
          check("mem_addr_held", 64'(ok), 64'd1);
          if (we_seen) mem_arr[int'(a)] = wd;
          else mem_rdata = mem_arr.exists(int'(a)) ? mem_arr[int'(a)] : 32'h0;
          mem_state = 4'd1;
        end else mem_state = 4'd0;
      end
    end
  end

  // Monitor: every ack pops one expectation (owner and both rdata registers).
  initial begin : monitor
    ack_t k;
    forever begin
      @(negedge iCLK);
      if (d_ack || i_ack) begin
        n_vec++;
        if (d_ack && i_ack) begin
          n_fail++;
          $display("FAIL ack_both: d_ack=%0d i_ack=%0d, required one-hot", d_ack, i_ack);
        end else if (ack_q.size() == 0) begin
          n_fail++;
          $display("FAIL ack_unexpected: d_ack=%0d i_ack=%0d, none queued", d_ack, i_ack);
        end else begin
          k = ack_q.pop_front();
          check("ack_port", 64'(i_ack), 64'(k.port));
          check("d_rdata", 64'(d_rdata), 64'(k.d_rd));
          check("i_rdata", 64'(i_rdata), 64'(k.i_rd));
        end
      end
    end
  end

  task automatic push_exp(input logic port, input logic we, input logic [26:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rd);
    op_t  o;
    ack_t k;
    if (!we) begin
      if (port) exp_i = rd;
      else      exp_d = rd;
    end
    o.we = we; o.addr = addr; o.wdata = wdata;
    op_q.push_back(o);
    k.port = port; k.d_rd = exp_d; k.i_rd = exp_i;
    ack_q.push_back(k);
  endtask

  // One transaction from one port, started from ARB; lat = negedges until ack.
  task automatic do_txn(input logic port, input logic we, input logic [26:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, output int lat);
    bit seen = 1'b0;
    lat = -1;
    @(posedge iCLK); #1;
    push_exp(port, we, addr, wdata, rd);
    if (port) begin i_req = 1'b1; i_addr = addr; end
    else begin d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; end
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge iCLK);
      if (port ? i_ack : d_ack) begin seen = 1'b1; lat = c; end
    end
    check("ack_seen", 64'(seen), 64'd1);
    @(posedge iCLK); #1;
    if (port) i_req = 1'b0; else d_req = 1'b0;
  endtask

  initial begin : stim
    logic [7:0] acc;
    int lat, d_cnt, i_cnt, n, first_to, ack_n;
    bit seen_req, hit;
    op_t o;
    iRST_n = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    i_req = 1'b0; i_addr = '0;
    mem_arr[32'h100] = 32'h3C011001;
    mem_arr[32'h300] = 32'h11112222;

    // Reset state
    #22;
    check("rst_mem_read_req", 64'(mem_read_req), 64'd0);
    check("rst_mem_write_req", 64'(mem_write_req), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_acks", 64'({d_ack, i_ack}), 64'd0);
    check("rst_rdata", 64'({d_rdata, i_rdata}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_timeout_err", 64'(timeout_err), 64'd0);

    // Controller stays in INIT for 20 cycles: nothing may be issued
    @(posedge iCLK); #1 iRST_n = 1'b1;
    acc = '0;
    repeat (20) begin
      @(negedge iCLK);
      acc |= {mem_read_req, mem_write_req, d_ack, i_ack, timeout_err,
              |d_rdata, |i_rdata, |mem_addr};
    end
    check("init_quiet", 64'(acc), 64'd0);
    ctrl_ready = 1'b1;
    repeat (4) @(posedge iCLK);

    // Both ports requesting continuously: D,I,D,I,D,I
    @(posedge iCLK); #1;
    for (int t = 0; t < 3; t++) begin
      push_exp(1'b0, 1'b0, 27'h300, 32'h0, 32'h11112222);
      push_exp(1'b1, 1'b0, 27'h100, 32'h0, 32'h3C011001);
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 27'h300;
    i_req = 1'b1; i_addr = 27'h100;
    d_cnt = 0; i_cnt = 0;
    for (int c = 0; c < 200 && (d_cnt < 3 || i_cnt < 3); c++) begin
      @(negedge iCLK);
      if (d_ack) d_cnt++;
      if (i_ack) i_cnt++;
      @(posedge iCLK); #1;
      if (d_cnt >= 3) d_req = 1'b0;
      if (i_cnt >= 3) i_req = 1'b0;
    end
    d_req = 1'b0; i_req = 1'b0;
    check("tie_d_acks", 64'(d_cnt), 64'd3);
    check("tie_i_acks", 64'(i_cnt), 64'd3);
    repeat (4) @(posedge iCLK);

    // Fetch-only read, minimum latency
    do_txn(1'b1, 1'b0, 27'h100, 32'h0, 32'h3C011001, lat);
    check("fetch_latency", 64'(lat), 64'd3);

    // Data write then read-back
    do_txn(1'b0, 1'b1, 27'h200, 32'hDEADBEEF, 32'h0, lat);
    do_txn(1'b0, 1'b0, 27'h200, 32'h0, 32'hDEADBEEF, lat);
    check("read_latency", 64'(lat), 64'd3);

    // Controller stalls: watchdog fires on cycle TIMEOUT-1, ack still follows
    busy_len = TIMEOUT + 5;
    @(posedge iCLK); #1;
    push_exp(1'b1, 1'b0, 27'h100, 32'h0, 32'h3C011001);
    i_req = 1'b1; i_addr = 27'h100;
    n = -1; first_to = -1; ack_n = -1;
    for (int c = 0; c < 200 && ack_n < 0; c++) begin
      @(negedge iCLK);
      if (n < 0 && mem_read_req) n = 0;
      else if (n >= 0) n++;
      if (n >= 0 && timeout_err && first_to < 0) first_to = n;
      if (i_ack) ack_n = n;
    end
    check("timeout_cycle", 64'(first_to), 64'(TIMEOUT - 1));
    check("stall_ack_cycle", 64'(ack_n), 64'(TIMEOUT + 6));
    @(posedge iCLK); #1 i_req = 1'b0;
    busy_len = 1;
    repeat (3) @(negedge iCLK);
    check("timeout_sticky", 64'(timeout_err), 64'd1);

    // Reset pulse during BUSY, then a normal read
    busy_len = 8;
    @(posedge iCLK); #1;
    o.we = 1'b0; o.addr = 27'h200; o.wdata = '0;
    op_q.push_back(o);
    d_req = 1'b1; d_we = 1'b0; d_addr = 27'h200;
    seen_req = 1'b0; hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      @(negedge iCLK);
      if (seen_req && !mem_read_req) hit = 1'b1;
      if (mem_read_req) seen_req = 1'b1;
    end
    check("reach_busy", 64'(hit), 64'd1);
    #2 iRST_n = 1'b0;
    #1;
    check("arst_mem_read_req", 64'(mem_read_req), 64'd0);
    check("arst_acks", 64'({d_ack, i_ack}), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_timeout_err", 64'(timeout_err), 64'd0);
    check("arst_rdata", 64'({d_rdata, i_rdata}), 64'd0);
    d_req = 1'b0;
    exp_d = '0; exp_i = '0;
    ack_q.delete();
    op_q.delete();
    repeat (2) @(negedge iCLK);
    #2 iRST_n = 1'b1;
    busy_len = 1;
    repeat (4) @(posedge iCLK);
    do_txn(1'b0, 1'b0, 27'h200, 32'h0, 32'hDEADBEEF, lat);
    check("post_rst_latency", 64'(lat), 64'd3);

    repeat (5) @(negedge iCLK);
    check("ack_q_drained", 64'(ack_q.size()), 64'd0);
    check("op_q_drained", 64'(op_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : guard
    #100000;
    $display("FAIL bench_timeout: simulation time limit reached before completion");
    $fatal(1, "bench timeout");
  end

endmodule
